// File: rtl/can_frame_receiver.sv
// CAN 2.0A bit-level frame receiver: destuffs, parses and checks one standard-ID frame
// and presents {RTR, ID, data} with DLC on frame completion.
module can_frame_receiver #(
    parameter int unsigned IDLE_BITS = 1,
    parameter logic [14:0] CRC_POLY  = 15'h4599
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        rxd,
    output logic [75:0] payload,
    output logic [3:0]  dlc,
    output logic        frame_valid,
    output logic        crc_err,
    output logic        stuff_err,
    output logic        form_err,
    output logic        busy
);
    typedef enum logic [3:0] {
        S_IDLE_WAIT, S_IDLE, S_ID, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERROR
    } state_t;

    localparam logic [3:0] IDLE_N = 4'(IDLE_BITS);

    state_t      state;
    logic [3:0]  idle_cnt;
    logic [6:0]  bit_cnt;
    logic        run_val;
    logic [2:0]  run_cnt;
    logic [14:0] crc_calc;
    logic [14:0] crc_rx;
    logic [10:0] id_rx;
    logic        rtr_rx;
    logic [3:0]  dlc_rx;
    logic [63:0] data_rx;

    logic        stuffed;
    logic        stuff_bit;
    logic [14:0] crc_step;
    logic [6:0]  data_bits;
    logic [3:0]  idle_inc;

    always_comb begin
        stuffed   = (state inside {S_ID, S_CTRL, S_DATA, S_CRC});
        stuff_bit = stuffed && (run_cnt == 3'd5);
        crc_step  = {crc_calc[13:0], 1'b0} ^ ((rxd ^ crc_calc[14]) ? CRC_POLY : '0);
        data_bits = (dlc_rx > 4'd8) ? 7'd64 : {dlc_rx, 3'b000};
        idle_inc  = idle_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE_WAIT;
            idle_cnt    <= '0;
            bit_cnt     <= '0;
            run_val     <= 1'b0;
            run_cnt     <= '0;
            crc_calc    <= '0;
            crc_rx      <= '0;
            id_rx       <= '0;
            rtr_rx      <= 1'b0;
            dlc_rx      <= '0;
            data_rx     <= '0;
            payload     <= '0;
            dlc         <= '0;
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            stuff_err   <= 1'b0;
            form_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            stuff_err   <= 1'b0;
            form_err    <= 1'b0;
            if (bit_en) begin
                if (stuff_bit) begin
                    if (rxd == run_val) begin
                        stuff_err <= 1'b1;
                        busy      <= 1'b0;
                        idle_cnt  <= '0;
                        state     <= S_ERROR;
                    end else begin
                        run_val <= rxd;
                        run_cnt <= 3'd1;
                    end
                end else begin
                    if (stuffed) begin
                        if (rxd == run_val) begin
                            run_cnt <= run_cnt + 3'd1;
                        end else begin
                            run_val <= rxd;
                            run_cnt <= 3'd1;
                        end
                    end
                    unique case (state)
                        S_IDLE_WAIT, S_ERROR: begin
                            if (rxd) begin
                                idle_cnt <= idle_inc;
                                if (idle_inc >= IDLE_N) state <= S_IDLE;
                            end else begin
                                idle_cnt <= '0;
                            end
                        end
                        S_IDLE: begin
                            if (!rxd) begin
                                state    <= S_ID;
                                busy     <= 1'b1;
                                crc_calc <= '0;
                                run_val  <= 1'b0;
                                run_cnt  <= 3'd1;
                                bit_cnt  <= '0;
                                data_rx  <= '0;
                            end
                        end
                        S_ID: begin
                            crc_calc <= crc_step;
                            id_rx    <= {id_rx[9:0], rxd};
                            if (bit_cnt == 7'd10) begin
                                bit_cnt <= '0;
                                state   <= S_CTRL;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                        S_CTRL: begin
                            crc_calc <= crc_step;
                            bit_cnt  <= bit_cnt + 7'd1;
                            if (bit_cnt == 7'd0) rtr_rx <= rxd;
                            if (bit_cnt >= 7'd3) dlc_rx <= {dlc_rx[2:0], rxd};
                            if (bit_cnt == 7'd1 && rxd) begin
                                form_err <= 1'b1;
                                busy     <= 1'b0;
                                idle_cnt <= '0;
                                state    <= S_ERROR;
                            end else if (bit_cnt == 7'd6) begin
                                bit_cnt <= '0;
                                // the last DLC bit is still on rxd, so decide on the shifted value
                                state <= (rtr_rx || {dlc_rx[2:0], rxd} == 4'd0) ? S_CRC : S_DATA;
                            end
                        end
                        S_DATA: begin
                            crc_calc <= crc_step;
                            data_rx[6'(7'd63 - bit_cnt)] <= rxd;
                            if (bit_cnt == data_bits - 7'd1) begin
                                bit_cnt <= '0;
                                state   <= S_CRC;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                        S_CRC: begin
                            crc_rx <= {crc_rx[13:0], rxd};
                            if (bit_cnt == 7'd14) begin
                                bit_cnt <= '0;
                                state   <= S_CRC_DEL;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                        S_CRC_DEL: begin
                            if (crc_rx != crc_calc) begin
                                crc_err  <= 1'b1;
                                busy     <= 1'b0;
                                idle_cnt <= '0;
                                state    <= S_ERROR;
                            end else if (!rxd) begin
                                form_err <= 1'b1;
                                busy     <= 1'b0;
                                idle_cnt <= '0;
                                state    <= S_ERROR;
                            end else begin
                                state <= S_ACK;
                            end
                        end
                        S_ACK: state <= S_ACK_DEL;
                        S_ACK_DEL: begin
                            if (!rxd) begin
                                form_err <= 1'b1;
                                busy     <= 1'b0;
                                idle_cnt <= '0;
                                state    <= S_ERROR;
                            end else begin
                                bit_cnt <= '0;
                                state   <= S_EOF;
                            end
                        end
                        S_EOF: begin
                            if (!rxd) begin
                                form_err <= 1'b1;
                                busy     <= 1'b0;
                                idle_cnt <= '0;
                                state    <= S_ERROR;
                            end else if (bit_cnt == 7'd6) begin
                                frame_valid <= 1'b1;
                                payload     <= {rtr_rx, id_rx, data_rx};
                                dlc         <= dlc_rx;
                                busy        <= 1'b0;
                                idle_cnt    <= 4'd7;
                                state       <= (IDLE_N == 4'd1) ? S_IDLE : S_IDLE_WAIT;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                        default: state <= S_IDLE_WAIT;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_can_frame_receiver.sv
// Directed bench for can_frame_receiver: a transmit-side frame builder feeds bit streams,
// and decoded fields, pulse counts and pulse positions are checked against hand-set values.
module tb_can_frame_receiver;
    logic        clk;
    logic        rst;
    logic        bit_en;
    logic        rxd;
    logic [75:0] payload;
    logic [3:0]  dlc;
    logic        frame_valid;
    logic        crc_err;
    logic        stuff_err;
    logic        form_err;
    logic        busy;

    can_frame_receiver #(.IDLE_BITS(1), .CRC_POLY(15'h4599)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rxd(rxd), .payload(payload), .dlc(dlc),
        .frame_valid(frame_valid), .crc_err(crc_err), .stuff_err(stuff_err),
        .form_err(form_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [75:0] P_NOM   = {1'b0, 11'h555, 64'h0123456789ABCDEF};
    localparam logic [75:0] P_SHORT = {1'b0, 11'h000, 64'h00FF000000000000};
    localparam logic [75:0] P_RTR   = {1'b1, 11'h123, 64'h0};
    localparam logic [75:0] P_D12   = {1'b0, 11'h7F0, 64'hFEDCBA9876543210};

    int   n_checks = 0;
    int   n_errors = 0;
    logic fb[$];
    int   sp[$];
    int   crc_del_idx, ide_idx;
    int   n_fv, n_crc, n_stf, n_frm, err_idx, fv_idx, gap_p;
    logic busy_sof, busy_end;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transmitter view of a frame: raw fields, CRC, then stuffing up to the last CRC bit.
    task automatic build(input logic [10:0] id, input logic rtr, input logic ide,
                         input logic [3:0] dl, input logic [63:0] d, input logic [14:0] crc_mask);
        logic        raw[$];
        logic [14:0] c;
        logic        nxt, last;
        int          nb, run;
        raw = {};
        fb  = {};
        sp  = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(ide);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dl[i]);
        nb = rtr ? 0 : ((dl > 4'd8) ? 64 : 8 * int'(dl));
        for (int i = 0; i < nb; i++) raw.push_back(d[63 - i]);
        c = '0;
        foreach (raw[i]) begin
            nxt = raw[i] ^ c[14];
            c = {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
        end
        c = c ^ crc_mask;
        for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
        run  = 0;
        last = 1'b1;
        foreach (raw[i]) begin
            if (i == 13) ide_idx = fb.size();
            fb.push_back(raw[i]);
            if (raw[i] == last) run++;
            else begin
                run  = 1;
                last = raw[i];
            end
            if (run == 5 && i < raw.size() - 1) begin
                sp.push_back(fb.size());
                fb.push_back(~raw[i]);
                last = ~raw[i];
                run  = 1;
            end
        end
        crc_del_idx = fb.size();
        fb.push_back(1'b1);
        fb.push_back(1'b0);
        fb.push_back(1'b1);
        repeat (7) fb.push_back(1'b1);
    endtask

    task automatic sample(input int k);
        if (frame_valid) begin n_fv++; fv_idx = k; end
        if (crc_err)     begin n_crc++; if (err_idx < 0) err_idx = k; end
        if (stuff_err)   begin n_stf++; if (err_idx < 0) err_idx = k; end
        if (form_err)    begin n_frm++; if (err_idx < 0) err_idx = k; end
    endtask

    // Drives fb; after the first error pulse the rest of the frame is replaced by recessive bits.
    task automatic send(input int gap, input int stop_at);
        n_fv = 0; n_crc = 0; n_stf = 0; n_frm = 0;
        err_idx = -1; fv_idx = -1; gap_p = 0;
        repeat (3) begin
            @(negedge clk); bit_en = 1'b1; rxd = 1'b1;
            @(posedge clk); #1;
        end
        for (int k = 0; k < fb.size(); k++) begin
            if (stop_at >= 0 && k == stop_at) break;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); bit_en = 1'b0; rxd = 1'($urandom);
                @(posedge clk); #1;
                if (frame_valid | crc_err | stuff_err | form_err) gap_p++;
            end
            @(negedge clk); bit_en = 1'b1; rxd = (err_idx >= 0) ? 1'b1 : fb[k];
            @(posedge clk); #1;
            if (k == 0) busy_sof = busy;
            sample(k);
        end
        if (stop_at < 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); bit_en = 1'b1; rxd = 1'b1;
                @(posedge clk); #1;
                sample(1000 + k);
            end
        end
        busy_end = busy;
    endtask

    task automatic expect_good(input string tag, input logic [75:0] p, input logic [3:0] d);
        check({tag, "_fv"}, 80'(n_fv), 80'(1));
        check({tag, "_errs"}, 80'(n_crc + n_stf + n_frm), 80'(0));
        check({tag, "_fv_idx"}, 80'(fv_idx), 80'(fb.size() - 1));
        check({tag, "_payload"}, 80'(payload), 80'(p));
        check({tag, "_dlc"}, 80'(dlc), 80'(d));
        check({tag, "_busy_sof"}, 80'(busy_sof), 80'(1));
        check({tag, "_busy_end"}, 80'(busy_end), 80'(0));
    endtask

    task automatic expect_err(input string tag, input int kind, input int idx, input logic [75:0] p);
        check({tag, "_crc_n"}, 80'(n_crc), 80'(kind == 0 ? 1 : 0));
        check({tag, "_stf_n"}, 80'(n_stf), 80'(kind == 1 ? 1 : 0));
        check({tag, "_frm_n"}, 80'(n_frm), 80'(kind == 2 ? 1 : 0));
        check({tag, "_err_idx"}, 80'(err_idx), 80'(idx));
        check({tag, "_no_fv"}, 80'(n_fv), 80'(0));
        check({tag, "_payload_kept"}, 80'(payload), 80'(p));
        check({tag, "_busy_end"}, 80'(busy_end), 80'(0));
    endtask

    initial begin
        rst = 1'b0; bit_en = 1'b0; rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_payload", 80'(payload), 80'(0));
        check("rst_dlc", 80'(dlc), 80'(0));
        check("rst_flags", 80'({frame_valid, crc_err, stuff_err, form_err, busy}), 80'(0));
        @(negedge clk); rst = 1'b1;

        build(11'h555, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF, 15'h0);
        send(0, -1);
        expect_good("nom", P_NOM, 4'd8);

        build(11'h000, 1'b0, 1'b0, 4'd2, 64'h00FF000000000000, 15'h0);
        check("short_first_stuff_pos", 80'(sp[0]), 80'(5));
        send(0, -1);
        expect_good("short", P_SHORT, 4'd2);

        build(11'h000, 1'b0, 1'b0, 4'd2, 64'h00FF000000000000, 15'h0);
        fb[sp[0]] = ~fb[sp[0]];
        send(0, -1);
        expect_err("stuff", 1, sp[0], P_SHORT);

        build(11'h555, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF, 15'h0001);
        send(0, -1);
        expect_err("crc", 0, crc_del_idx, P_SHORT);

        build(11'h555, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF, 15'h0);
        send(0, -1);
        expect_good("after_crc", P_NOM, 4'd8);

        build(11'h2AA, 1'b0, 1'b0, 4'd2, 64'h00FF000000000000, 15'h0);
        fb[crc_del_idx + 2] = 1'b0;
        send(0, -1);
        expect_err("ackdel", 2, crc_del_idx + 2, P_NOM);

        build(11'h2AA, 1'b0, 1'b0, 4'd2, 64'h00FF000000000000, 15'h0);
        fb[crc_del_idx + 3 + 4] = 1'b0;
        send(0, -1);
        expect_err("eof4", 2, crc_del_idx + 7, P_NOM);

        build(11'h2AA, 1'b0, 1'b1, 4'd2, 64'h00FF000000000000, 15'h0);
        send(0, -1);
        expect_err("ide", 2, ide_idx, P_NOM);

        build(11'h123, 1'b1, 1'b0, 4'd5, 64'hA5A5A5A5A5A5A5A5, 15'h0);
        send(0, -1);
        expect_good("rtr", P_RTR, 4'd5);

        build(11'h7F0, 1'b0, 1'b0, 4'd12, 64'hFEDCBA9876543210, 15'h0);
        send(0, -1);
        expect_good("dlc12", P_D12, 4'd12);

        build(11'h555, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF, 15'h0);
        send(2, -1);
        expect_good("gapped", P_NOM, 4'd8);
        check("gapped_gap_pulses", 80'(gap_p), 80'(0));

        build(11'h7F0, 1'b0, 1'b0, 4'd12, 64'hFEDCBA9876543210, 15'h0);
        send(0, 40);
        check("mid_busy", 80'(busy_end), 80'(1));
        check("mid_no_pulse", 80'(n_fv + n_crc + n_stf + n_frm), 80'(0));
        @(negedge clk); rst = 1'b0;
        #1;
        check("mid_rst_payload", 80'(payload), 80'(0));
        check("mid_rst_dlc", 80'(dlc), 80'(0));
        check("mid_rst_busy", 80'(busy), 80'(0));
        @(negedge clk); rst = 1'b1;

        build(11'h000, 1'b0, 1'b0, 4'd2, 64'h00FF000000000000, 15'h0);
        send(0, -1);
        expect_good("post_rst", P_SHORT, 4'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/can_frame_receiver.md
Name: can_frame_receiver

Overview:
- Bit-level CAN 2.0A (standard 11-bit ID) frame receiver/decoder.
- Consumes the serial bit stream that the bench CAN frame generator drives: one bit per enabled clock, recessive = 1, no bit-timing or sync logic.
- Removes stuff bits, parses the fields, checks CRC-15 and the fixed-form fields, then presents ID/RTR/DLC/data as a 76-bit payload.
- Used as the bus monitor/checker on the MOPS side of the testbench and as the RX front end of the hub model.

Parameters:
- IDLE_BITS, 1, consecutive recessive bits required (after reset or error) before an SOF is accepted; legal range 1..15.
- CRC_POLY, 15'h4599, CRC-15 generator polynomial (CAN).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- bit_en  input  1  qualifies rxd; the block samples only when high (tie high for one bit per clk)
- rxd  input  1  serial CAN bit stream, 1 = recessive
- payload  output  76  [75]=RTR, [74:64]=ID, [63:0]=data; byte 0 in [63:56]; unused bytes 0
- dlc  output  4  received DLC, as transmitted (0..15)
- frame_valid  output  1  one-cycle pulse: good frame; payload/dlc valid from this cycle
- crc_err  output  1  one-cycle pulse: CRC mismatch
- stuff_err  output  1  one-cycle pulse: stuff rule violated
- form_err  output  1  one-cycle pulse: fixed-form bit wrong or IDE=1
- busy  output  1  high from SOF accepted until frame end or error

Behaviour:
- Reset (async, rst=0):
  - All outputs 0, state IDLE_WAIT, counters cleared.
  - Reset mid-frame discards the frame; payload/dlc are cleared.
- bit_en=0: state, counters, CRC and stuff history hold; pulse outputs are 0.
- States:
  - IDLE_WAIT: count consecutive 1s; a 0 restarts the count; at IDLE_BITS go to IDLE.
  - IDLE: rxd=0 is SOF; go to ID with busy=1; CRC init 0; stuff history = SOF bit.
  - ID: 11 bits, MSB first.
  - CTRL: RTR, IDE, r0, DLC[3:0] MSB first. IDE=1 gives form_err.
  - DATA: 8*min(DLC,8) bits, MSB first; skipped when RTR=1 or DLC=0.
  - CRC: 15 bits.
  - CRC_DEL (must be 1), ACK (any value, ignored), ACK_DEL (must be 1).
  - EOF: 7 bits, all must be 1.
  - ERROR: waits IDLE_BITS consecutive 1s, then IDLE; busy=0.
- Destuffing:
  - Applies from SOF through the last CRC bit only.
  - After 5 consecutive equal bits, the next sampled bit is a stuff bit. It is discarded and not fed to CRC or fields. It resets the run count to 1 with its own value.
  - A stuff bit equal to the run value gives stuff_err, then ERROR.
  - CRC_DEL onward is never destuffed.
- CRC:
  - Computed over destuffed SOF..last data bit. Per bit: nxt = bit ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? CRC_POLY : 0).
  - The received 15 bits are compared at CRC_DEL.
  - Mismatch gives crc_err. It takes priority over a CRC_DEL form error in the same bit, and only crc_err is pulsed. Then ERROR.
- Form errors: CRC_DEL=0, ACK_DEL=0, any EOF bit 0, or IDE=1 give form_err, then ERROR. The EOF check covers all 7 bits.
- Error/valid timing:
  - All error pulses assert the clk after the offending bit is sampled.
  - Only one error pulse per frame; payload/dlc are unchanged on error.
- Frame completion, in the clk after the 7th EOF bit:
  - frame_valid=1 for one cycle.
  - payload/dlc updated in the same cycle and held until the next frame_valid or reset.
  - busy=0; go to IDLE when IDLE_BITS=1, otherwise IDLE_WAIT (EOF bits count toward the idle run).
- DLC > 8: 8 data bytes are received; dlc reports the raw value.
- Latency: SOF to frame_valid = number of sampled bits in the frame (stuff bits included) + 1 clk.

Test Plan:
- Nominal frame, one bit per clk: ID=0x555, RTR=0, DLC=8, data=64'h0123456789ABCDEF, reference-model CRC and stuffing → one frame_valid, payload={1'b0,11'h555,64'h0123456789ABCDEF}, dlc=8, no error pulses.
- Stuffing plus short frame: ID=0x000, DLC=2, data bytes 0x00,0xFF (several stuff bits) → frame_valid, payload[63:48]=16'h00FF, payload[47:0]=0; then flip one stuff bit → stuff_err once, no frame_valid, payload unchanged.
- Corrupted CRC: nominal frame with CRC bit 0 inverted → crc_err one cycle after CRC_DEL sampled, busy falls, next clean frame received normally.
- Form faults: separate runs with ACK_DEL=0, EOF bit 4=0, and IDE=1 → form_err one cycle after the faulty bit; no frame_valid in each case.
- Edge cases:
  - RTR=1, DLC=5 → no data bits consumed, payload[75]=1, payload[63:0]=0, dlc=5.
  - DLC=12 → 8 data bytes received, dlc=12.
- Control: bit_en toggled 1-of-3 clocks during a nominal frame → identical result to the continuous run.
- Reset mid-DATA → outputs 0, the following frame is decoded correctly.
